// File: rtl/gpio_bus_if.sv
// Data-memory bus slice seen by the GPIO input port: ALU address, store data,
// store strobe and the combinational read return used by the load-path mux.
interface gpio_bus_if;
   logic [31:0] Address;
   logic [31:0] Wdata;
   logic        MemW;
   logic [31:0] rd_data;
   logic        rd_hit;

   modport master (output Address, Wdata, MemW, input rd_data, rd_hit);
   modport slave  (input Address, Wdata, MemW, output rd_data, rd_hit);
endinterface

// File: rtl/gpio_in_port.sv
// GPIO input peripheral: per-pin 2-flop sync + debounce, edge detection into
// sticky W1C status, and a 4-word register block read back combinationally.

module gpio_in_lane #(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic deb,
   output logic rise,
   output logic fall
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic             s1, s2, deb_q;
   logic [CNT_W-1:0] cnt;

   // plain two-flop synchroniser, nothing between the stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= pin;
         s2 <= s1;
      end
   end

   // cnt counts consecutive cycles s2 has disagreed with deb
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb <= 1'b0;
         cnt <= '0;
      end else if (s2 == deb) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         deb <= s2;
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) deb_q <= 1'b0;
      else     deb_q <= deb;
   end

   assign rise = deb & ~deb_q;
   assign fall = ~deb & deb_q;
endmodule

module gpio_in_port #(
   parameter int          WIDTH      = 8,
   parameter int          DEB_CYCLES = 4,
   parameter int          CNT_W      = 3,
   parameter logic [31:0] BASE       = 32'h0000ABD0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pin_in,
   gpio_bus_if.slave        bus,
   output logic             irq
);
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_RISE   = 2'd2;
   localparam logic [1:0] REG_FALL   = 2'd3;

   logic [WIDTH-1:0] deb, rise, fall;
   logic [WIDTH-1:0] status, rise_en, fall_en;
   logic [WIDTH-1:0] set, clr, wd;
   logic [1:0]       sel;
   logic             wr;
   logic             unused_bus;

   gpio_in_lane #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_lane [WIDTH-1:0] (
      .clk  (clk),
      .rst  (rst),
      .pin  (pin_in),
      .deb  (deb),
      .rise (rise),
      .fall (fall)
   );

   assign bus.rd_hit = (bus.Address[31:4] == BASE[31:4]);
   assign sel        = bus.Address[3:2];
   assign wr         = bus.MemW && bus.rd_hit;
   assign wd         = bus.Wdata[WIDTH-1:0];
   assign unused_bus = &{1'b0, bus.Address[1:0], bus.Wdata};

   // enables are sampled before this cycle's write lands
   assign set = (rise & rise_en) | (fall & fall_en);
   assign clr = (wr && sel == REG_STATUS) ? wd : '0;

   // set is OR'd after the clear so a coincident edge keeps its bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) status <= '0;
      else     status <= (status & ~clr) | set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_en <= '0;
         fall_en <= '0;
      end else if (wr) begin
         if (sel == REG_RISE) rise_en <= wd;
         if (sel == REG_FALL) fall_en <= wd;
      end
   end

   assign irq = |status;

   always_comb begin
      bus.rd_data = '0;
      if (bus.rd_hit) begin
         case (sel)
            REG_DATA:   bus.rd_data = 32'(deb);
            REG_STATUS: bus.rd_data = 32'(status);
            REG_RISE:   bus.rd_data = 32'(rise_en);
            REG_FALL:   bus.rd_data = 32'(fall_en);
            default:    bus.rd_data = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_gpio_in_port.sv
// Randomised + directed check of gpio_in_port against a cycle-level reference
// model built from the debounce/edge/register rules.
module tb_gpio_in_port;
   localparam int DEB = 4;
   localparam logic [31:0] A_DATA = 32'h0000ABD0;
   localparam logic [31:0] A_STAT = 32'h0000ABD4;
   localparam logic [31:0] A_RISE = 32'h0000ABD8;
   localparam logic [31:0] A_FALL = 32'h0000ABDC;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pin;
   logic       irq;
   int         vectors = 0;
   int         miscompares = 0;

   gpio_bus_if bus ();

   gpio_in_port #(.WIDTH(8), .DEB_CYCLES(DEB), .CNT_W(3), .BASE(32'h0000ABD0)) dut (
      .clk    (clk),
      .rst    (rst),
      .pin_in (pin),
      .bus    (bus),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [7:0] m_s1, m_s2, m_deb, m_debq, m_stat, m_ren, m_fen;
   int         m_run [8];

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_debq = 0;
      m_stat = 0; m_ren = 0; m_fen = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
   endtask

   function automatic logic m_hit(input logic [31:0] a);
      return a[31:4] == 28'h0000ABD;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (!m_hit(a)) return 32'h0;
      case (a[3:2])
         2'd0:    return {24'h0, m_deb};
         2'd1:    return {24'h0, m_stat};
         2'd2:    return {24'h0, m_ren};
         default: return {24'h0, m_fen};
      endcase
   endfunction

   // one clock edge worth of behaviour, using the inputs present before the edge
   task automatic model_step();
      logic [7:0] setv, clrv;
      logic       wr;
      setv = ((m_deb & ~m_debq) & m_ren) | ((~m_deb & m_debq) & m_fen);
      wr   = bus.MemW && m_hit(bus.Address);
      clrv = (wr && bus.Address[3:2] == 2'd1) ? bus.Wdata[7:0] : 8'h0;
      m_stat = (m_stat & ~clrv) | setv;
      if (wr && bus.Address[3:2] == 2'd2) m_ren = bus.Wdata[7:0];
      if (wr && bus.Address[3:2] == 2'd3) m_fen = bus.Wdata[7:0];
      m_debq = m_deb;
      // a new level is accepted once it has disagreed for DEB consecutive cycles
      for (int i = 0; i < 8; i++) begin
         if (m_s2[i] != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] >= DEB) begin
               m_deb[i] = m_s2[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = pin;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.Address = a;
      bus.MemW    = 1'b0;
      #1;
      d = bus.rd_data;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.Address = a;
      bus.Wdata   = d;
      bus.MemW    = 1'b1;
      tick();
      bus.MemW    = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1; pin = 8'h00;
      bus.Address = 32'h0; bus.Wdata = 32'h0; bus.MemW = 1'b0;
      model_reset();
      ticks(3);
      rst = 1'b0;
      ticks(2);
      for (int r = 0; r < 4; r++) begin
         rd(A_DATA + 32'(4 * r), d);
         vectors++;
         if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_reg%0d: got %h want 00000000", r, d);
         end
      end
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_irq: got %b want 0", irq);
      end
      rd(32'h0000ABCC, d);
      vectors++;
      if (bus.rd_hit !== 1'b0 || d !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_miss: got hit=%b data=%h want hit=0 data=0", bus.rd_hit, d);
      end
   endtask

   task automatic test_rise();
      logic [31:0] d, exp;
      wr(A_RISE, 32'h1);
      pin[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         rd(A_DATA, d);
         exp = (k == 6) ? 32'h1 : 32'h0;
         vectors++;
         if (d !== exp) begin
            miscompares++;
            $display("FAIL rise_data_edge%0d: got %h want %h", k, d, exp);
         end
      end
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("FAIL rise_irq_early: got %b want 0", irq);
      end
      tick();
      rd(A_STAT, d);
      vectors++;
      if (d !== 32'h1 || irq !== 1'b1) begin
         miscompares++;
         $display("FAIL rise_status: got stat=%h irq=%b want stat=00000001 irq=1", d, irq);
      end
   endtask

   task automatic test_glitch();
      logic [31:0] d, s;
      wr(A_RISE, 32'hFF);
      wr(A_FALL, 32'hFF);
      wr(A_STAT, 32'hFF);
      pin[1] = 1'b1;
      ticks(3);
      pin[1] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         rd(A_DATA, d);
         rd(A_STAT, s);
         vectors++;
         if (d !== 32'h1 || s !== 32'h0) begin
            miscompares++;
            $display("FAIL glitch_cycle%0d: got data=%h stat=%h want data=00000001 stat=0", k, d, s);
         end
      end
   endtask

   task automatic test_w1c();
      logic [31:0] d;
      wr(A_FALL, 32'h0);
      wr(A_RISE, 32'h3);
      pin = 8'h00;
      ticks(10);
      wr(A_STAT, 32'hFF);
      pin = 8'h03;
      ticks(8);
      rd(A_STAT, d);
      vectors++;
      if (d !== 32'h3) begin
         miscompares++;
         $display("FAIL w1c_setup: got %h want 00000003", d);
      end
      wr(A_STAT, 32'h1);
      rd(A_STAT, d);
      vectors++;
      if (d !== 32'h2 || irq !== 1'b1) begin
         miscompares++;
         $display("FAIL w1c_clear: got stat=%h irq=%b want stat=00000002 irq=1", d, irq);
      end
      wr(A_FALL, 32'h2);
      pin[1] = 1'b0;
      ticks(6);
      wr(A_STAT, 32'h2);
      rd(A_STAT, d);
      vectors++;
      if (d !== 32'h2) begin
         miscompares++;
         $display("FAIL w1c_set_wins: got %h want 00000002", d);
      end
   endtask

   task automatic test_fall_reset();
      logic [31:0] d, s;
      wr(A_STAT, 32'hFF);
      wr(A_RISE, 32'h0);
      wr(A_FALL, 32'h80);
      pin = 8'h80;
      ticks(8);
      wr(A_STAT, 32'hFF);
      pin = 8'h00;
      ticks(7);
      rd(A_STAT, d);
      vectors++;
      if (d !== 32'h80) begin
         miscompares++;
         $display("FAIL fall_status: got %h want 00000080", d);
      end
      pin[2] = 1'b1;
      ticks(3);
      rst = 1'b1;
      model_reset();
      for (int r = 0; r < 4; r++) begin
         rd(A_DATA + 32'(4 * r), d);
         vectors++;
         if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_reg%0d: got %h want 00000000", r, d);
         end
      end
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_irq: got %b want 0", irq);
      end
      ticks(2);
      rst = 1'b0;
      ticks(10);
      rd(A_DATA, d);
      rd(A_STAT, s);
      vectors++;
      if (d !== 32'h4 || s !== 32'h0 || irq !== 1'b0) begin
         miscompares++;
         $display("FAIL postreset: got data=%h stat=%h irq=%b want data=00000004 stat=0 irq=0", d, s, irq);
      end
   endtask

   task automatic test_data_ro();
      logic [31:0] d;
      wr(A_DATA, 32'hFFFF_FFFF);
      rd(A_DATA, d);
      vectors++;
      if (d !== 32'h4) begin
         miscompares++;
         $display("FAIL data_ro: got %h want 00000004", d);
      end
      wr(A_RISE, 32'h1FF);
      rd(A_RISE, d);
      vectors++;
      if (d !== 32'hFF) begin
         miscompares++;
         $display("FAIL rise_en_width: got %h want 000000ff", d);
      end
      rd(32'h0000ABDB, d);
      vectors++;
      if (d !== 32'hFF) begin
         miscompares++;
         $display("FAIL byte_offset: got %h want 000000ff", d);
      end
      rd(32'h0000ABE8, d);
      vectors++;
      if (bus.rd_hit !== 1'b0 || d !== 32'h0) begin
         miscompares++;
         $display("FAIL decode_miss: got hit=%b data=%h want hit=0 data=0", bus.rd_hit, d);
      end
   endtask

   task automatic test_random();
      logic [31:0] d, a, exp;
      int          hold;
      hold = 0;
      for (int n = 0; n < 600; n++) begin
         if (hold == 0) begin
            pin  = 8'($urandom);
            hold = $urandom_range(1, 8);
         end
         hold--;
         if ($urandom_range(0, 3) == 0) begin
            a = ($urandom_range(0, 5) == 0) ? 32'h0000ABE4 : A_DATA + 32'(4 * $urandom_range(0, 3));
            wr(a, $urandom);
         end else begin
            tick();
         end
         for (int r = 0; r < 4; r++) begin
            a = A_DATA + 32'(4 * r);
            rd(a, d);
            exp = model_read(a);
            vectors++;
            if (d !== exp || bus.rd_hit !== 1'b1) begin
               miscompares++;
               $display("FAIL random_n%0d_reg%0d: got %h hit=%b want %h hit=1", n, r, d, bus.rd_hit, exp);
            end
         end
         vectors++;
         if (irq !== (|m_stat)) begin
            miscompares++;
            $display("FAIL random_irq_n%0d: got %b want %b", n, irq, |m_stat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_glitch();
      test_w1c();
      test_fall_reset();
      test_data_ro();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/gpio_in_port.md
Name: gpio_in_port

Overview:
- Memory-mapped GPIO input peripheral; the read-side counterpart of the core's GPIO output register.
- Synchronises and debounces external input pins, then detects rising and falling edges into sticky status bits.
- Exposes data, status and enable registers on the core's data-memory bus (ALU address, store data, MemW).
- Read data is returned combinationally, in the same cycle, so the load path can select it alongside DataMem read data.

Parameters:
- WIDTH, 8, number of input pins (1..32).
- DEB_CYCLES, 4, cycles a synchronised value must stay stable before it is accepted (>=1).
- CNT_W, 3, debounce counter width; must satisfy 2^CNT_W >= DEB_CYCLES.
- BASE, 32'h0000ABD0, register block base address; 16-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pin_in  in  WIDTH  external asynchronous input pins.
- Address  in  32  data-memory byte address from the ALU.
- Wdata  in  32  store data (store-block output).
- MemW  in  1  store strobe for the current instruction.
- rd_data  out  32  register read data; combinational from Address.
- rd_hit  out  1  high when Address[31:4]==BASE[31:4]; the load-path mux selects rd_data when high.
- irq  out  1  OR of all EDGE_STATUS bits.

Behaviour:
- Reset (asynchronous, active-high): sync stages, debounced value, all counters, EDGE_STATUS, RISE_EN and FALL_EN go to 0. irq = 0. rd_data is 0 when rd_hit is low.
- Reset asserted mid-debounce discards the pending value and clears the counter.
- Synchroniser: two flops per bit, pin_in -> s1 -> s2. No logic between s1 and s2.
- Debounce (per bit):
  - When s2 == deb, cnt is set to 0.
  - When s2 != deb and cnt == DEB_CYCLES-1, deb takes s2 and cnt is set to 0.
  - Otherwise cnt increments.
  - A clean pin change therefore appears on deb 2+DEB_CYCLES clock edges after it is sampled.
  - A glitch shorter than DEB_CYCLES cycles at s2 never reaches deb.
- Edge detect: registered deb_q = previous deb.
  - rise = deb & ~deb_q; fall = ~deb & deb_q.
  - set = (rise & RISE_EN) | (fall & FALL_EN).
- Register map (Address[3:2]; Address[1:0] ignored):
  - 0 DATA: RO, {zero, deb}.
  - 1 EDGE_STATUS: sticky, W1C.
  - 2 RISE_EN: RW.
  - 3 FALL_EN: RW.
  - Bits above WIDTH-1 read 0 and ignore writes.
- Write: on a clk edge with MemW && rd_hit, word writes only.
  - DATA writes are ignored.
  - STATUS: next = (STATUS & ~Wdata) | set.
  - Set and clear of the same bit in the same cycle: set wins, the bit stays 1.
- Enables: an edge occurring in the same cycle an enable is written uses the old enable value.
- Clearing an enable does not clear an already-set status bit.
- irq is registered-path only: it rises one cycle after the edge reaches deb.
- Pins high out of reset: deb rises after 2+DEB_CYCLES cycles. With enables at 0, no status bit is set.

Test Plan:
- Reset then rst=0 with pin_in=8'h00 -> DATA, STATUS, RISE_EN, FALL_EN read 0; irq=0; rd_hit=0 for Address=32'h0000ABCC.
- Write RISE_EN=8'h01; pin_in[0] 0->1 held -> DATA reads 8'h01 exactly 6 edges later (DEB_CYCLES=4); STATUS=8'h01; irq=1 one cycle after.
- pin_in[1] pulse of 3 cycles with FALL_EN=RISE_EN=8'hFF -> DATA bit1 stays 0; STATUS stays 0.
- STATUS=8'h03; write Wdata=32'h1 to ABD4 -> STATUS=8'h02, irq=1. Write 32'h2 in the same cycle a bit1 edge sets it -> STATUS bit1 stays 1.
- FALL_EN=8'h80; pin_in[7] 1->0 after stable high -> STATUS=8'h80. Assert rst mid-debounce of another bit -> all registers 0, no edge logged after release.
- Write 32'hFFFF_FFFF to ABD0 -> DATA unchanged. Read ABD8 after writing 32'h1FF -> 32'h000000FF.
